// File: rtl/banco_registros_sb_pkg.sv
// Shared constants and helpers for the scoreboarded register bank.
package banco_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;

    // Net change in the busy population from one newly set and/or one newly cleared bit.
    function automatic logic signed [1:0] popcount_delta(input logic set, input logic clr);
        logic signed [1:0] delta;
        case ({set, clr})
            2'b10:   delta = 2'sb01;
            2'b01:   delta = 2'sb11;
            default: delta = 2'sb00;
        endcase
        return delta;
    endfunction

endpackage

// File: rtl/banco_registros_sb_if.sv
// Write, reserve and read-port bundle of the register bank.
interface banco_registros_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       we;
    logic [ADDR_W-1:0]          wa;
    logic [DATA_W-1:0]          data_in;
    logic                       rsv_en;
    logic [ADDR_W-1:0]          rsv_addr;
    logic [NUM_RD*ADDR_W-1:0]   ra;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic [NUM_RD-1:0]          rd_busy;
    logic [ADDR_W:0]            busy_cnt;

    modport master (
        output we, wa, data_in, rsv_en, rsv_addr, ra,
        input  rdata, rd_busy, busy_cnt
    );

    modport slave (
        input  we, wa, data_in, rsv_en, rsv_addr, ra,
        output rdata, rd_busy, busy_cnt
    );
endinterface

// File: rtl/banco_registros_sb_busy.sv
// Per-register busy bits plus a registered count of how many are set.
module sb_busy_tracker
    import banco_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      wa,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        busy_cnt
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]    busy_cnt_q, busy_cnt_d;
    logic               clr_en, set_en, set_new, clr_new;
    logic signed [1:0]  delta;

    // A reserve and a writeback on the same register leave it busy: the reserve is younger.
    always_comb begin
        clr_en     = we && !((ZERO_REG != 0) && (wa == ADDR_W'(ZERO_ADDR)));
        set_en     = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_ADDR)));
        set_new    = set_en && !busy_q[rsv_addr];
        clr_new    = clr_en && busy_q[wa] && !(set_en && (rsv_addr == wa));
        delta      = popcount_delta(set_new, clr_new);
        busy_d     = busy_q;
        if (clr_en) busy_d[wa] = 1'b0;
        if (set_en) busy_d[rsv_addr] = 1'b1;
        busy_cnt_d = busy_cnt_q + {{(ADDR_W-1){delta[1]}}, delta};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/banco_registros_sb.sv
// Register bank with write-through bypass, hardwired zero register and RAW scoreboard.
module banco_registros_sb
    import banco_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    banco_registros_sb_if.slave   bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]          mem_q [DEPTH];
    logic [DATA_W-1:0]          mem_d [DEPTH];
    logic                       wr_en;
    logic [DEPTH-1:0]           busy;
    logic [ADDR_W:0]            busy_cnt;
    logic [NUM_RD*DATA_W-1:0]   rdata_c;
    logic [NUM_RD-1:0]          rd_busy_c;
    logic [ADDR_W-1:0]          addr;
    logic                       is_zero, wr_hit, rsv_hit;

    sb_busy_tracker #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (bus.we),
        .wa       (bus.wa),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_comb begin
        wr_en = bus.we && !((ZERO_REG != 0) && (bus.wa == ADDR_W'(ZERO_ADDR)));
        mem_d = mem_q;
        if (wr_en) mem_d[bus.wa] = bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Outputs are forced quiet during reset so a bypassed write cannot leak out.
    always_comb begin
        rdata_c   = '0;
        rd_busy_c = '0;
        addr      = '0;
        is_zero   = 1'b0;
        wr_hit    = 1'b0;
        rsv_hit   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            addr    = bus.ra[i*ADDR_W +: ADDR_W];
            is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));
            wr_hit  = bus.we && (bus.wa == addr);
            rsv_hit = bus.rsv_en && (bus.rsv_addr == addr);
            if (rst_n && !is_zero) begin
                rdata_c[i*DATA_W +: DATA_W] = wr_hit ? bus.data_in : mem_q[addr];
                rd_busy_c[i]                = busy[addr] && !(wr_hit && !rsv_hit);
            end
        end
    end

    assign bus.rdata    = rdata_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_cnt = busy_cnt;
endmodule

// File: tb/tb_banco_registros_sb.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_banco_registros_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    typedef struct {
        string            name;
        logic [NR*DW-1:0] rdata;
        logic [NR-1:0]    rd_busy;
        logic [AW:0]      cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t exp_q[$];
    int   checks_total;
    int   checks_passed;

    logic [DW-1:0] ref_mem  [32];
    bit            ref_busy [32];

    banco_registros_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    banco_registros_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [NR*AW-1:0] pack_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                                 input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        return AW'($urandom_range(0, 31));
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            ref_mem[r]  = '0;
            ref_busy[r] = 1'b0;
        end
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int r = 0; r < 32; r++) n += ref_busy[r] ? 1 : 0;
        return n;
    endfunction

    // One cycle: drive just after the edge, predict the combinational view, then commit the edge.
    task automatic apply_stimulus(input bit hold_reset, input logic we_i, input logic [AW-1:0] wa_i,
                                  input logic [DW-1:0] d_i, input logic rsv_i, input logic [AW-1:0] rsva_i,
                                  input logic [NR*AW-1:0] ra_i, input string nm);
        exp_t        e;
        logic [AW-1:0] a;
        bit          wr_hit, rsv_hit;
        @(posedge clk);
        #1;
        rst_n        = !hold_reset;
        bus.we       = we_i;
        bus.wa       = wa_i;
        bus.data_in  = d_i;
        bus.rsv_en   = rsv_i;
        bus.rsv_addr = rsva_i;
        bus.ra       = ra_i;
        e.name    = nm;
        e.rdata   = '0;
        e.rd_busy = '0;
        e.cnt     = '0;
        if (hold_reset) begin
            model_clear();
        end else begin
            e.cnt = (AW+1)'(model_count());
            for (int i = 0; i < NR; i++) begin
                a       = ra_i[i*AW +: AW];
                wr_hit  = we_i && (wa_i == a);
                rsv_hit = rsv_i && (rsva_i == a);
                if (a != 0) begin
                    e.rdata[i*DW +: DW] = wr_hit ? d_i : ref_mem[a];
                    e.rd_busy[i]        = ref_busy[a] && !(wr_hit && !rsv_hit);
                end
            end
            if (we_i && wa_i != 0) begin
                ref_mem[wa_i]  = d_i;
                ref_busy[wa_i] = 1'b0;
            end
            if (rsv_i && rsva_i != 0) ref_busy[rsva_i] = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        for (int i = 0; i < NR; i++) begin
            checks_total++;
            if (bus.rdata[i*DW +: DW] === e.rdata[i*DW +: DW]) checks_passed++;
            else $display("[TB] FAIL %s rdata[%0d] got %h expected %h", e.name, i,
                          bus.rdata[i*DW +: DW], e.rdata[i*DW +: DW]);
            checks_total++;
            if (bus.rd_busy[i] === e.rd_busy[i]) checks_passed++;
            else $display("[TB] FAIL %s rd_busy[%0d] got %b expected %b", e.name, i,
                          bus.rd_busy[i], e.rd_busy[i]);
        end
        checks_total++;
        if (bus.busy_cnt === e.cnt) checks_passed++;
        else $display("[TB] FAIL %s busy_cnt got %0d expected %0d", e.name, bus.busy_cnt, e.cnt);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : stimulus
        clk           = 1'b0;
        rst_n         = 1'b0;
        checks_total  = 0;
        checks_passed = 0;
        bus.we        = 1'b0;
        bus.wa        = '0;
        bus.data_in   = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
        bus.ra        = '0;
        model_clear();

        apply_stimulus(1, 1, 5'd5, 32'hCAFE0001, 1, 5'd6, pack_ra(5'd5, 5'd6, 5'd0, 5'd1), "in_reset");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd0, 5'd1, 5'd2, 5'd5), "after_reset");

        apply_stimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, pack_ra(5'd5, 5'd4, 5'd0, 5'd6), "bypass");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd5, 5'd5, 5'd1, 5'd0), "read_back");

        apply_stimulus(0, 1, 5'd0, 32'h1234, 1, 5'd0, pack_ra(5'd0, 5'd5, 5'd0, 5'd0), "zero_wr_rsv");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd0, 5'd0, 5'd5, 5'd0), "zero_after");

        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd7, pack_ra(5'd7, 5'd5, 5'd0, 5'd7), "rsv7");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd7, 5'd5, 5'd0, 5'd1), "busy7");
        apply_stimulus(0, 1, 5'd7, 32'hA5, 0, 5'd0, pack_ra(5'd7, 5'd7, 5'd5, 5'd0), "wb7");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd7, 5'd5, 5'd0, 5'd2), "free7");

        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd9, pack_ra(5'd9, 5'd0, 5'd0, 5'd0), "rsv9");
        apply_stimulus(0, 1, 5'd9, 32'h11, 1, 5'd9, pack_ra(5'd9, 5'd7, 5'd5, 5'd9), "wr_rsv9");
        apply_stimulus(0, 0, 5'd0, 32'h0, 1, 5'd9, pack_ra(5'd9, 5'd7, 5'd5, 5'd0), "rersv9");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd9, 5'd8, 5'd10, 5'd0), "after9");

        for (int r = 1; r < 32; r++)
            apply_stimulus(0, 0, 5'd0, 32'h0, 1, AW'(r),
                           pack_ra(AW'(r), AW'(r - 1), rnd_addr(), rnd_addr()), "fill");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd31, 5'd1, 5'd16, 5'd0), "full");
        for (int r = 1; r < 32; r++)
            apply_stimulus(0, 1, AW'(r), $urandom, 0, 5'd0,
                           pack_ra(AW'(r), AW'(r - 1), rnd_addr(), rnd_addr()), "drain");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd31, 5'd1, 5'd16, 5'd9), "drained");

        for (int n = 0; n < 300; n++)
            apply_stimulus(0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                           1'($urandom_range(0, 1)), rnd_addr(),
                           pack_ra(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr()), "random");

        apply_stimulus(0, 1, 5'd12, 32'h5A5A5A5A, 1, 5'd13, pack_ra(5'd12, 5'd13, 5'd0, 5'd3), "pre_drop");
        apply_stimulus(1, 1, 5'd12, 32'h77777777, 1, 5'd14, pack_ra(5'd12, 5'd14, 5'd13, 5'd0), "drop_wr");
        apply_stimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, pack_ra(5'd12, 5'd13, 5'd14, 5'd7), "lost_wr");

        repeat (4) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks_total++;
            $display("[TB] FAIL drain_queue pending %0d expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
